// File: rtl/candidate_generator_pkg.sv
// Shared definitions for the password candidate generator: default charset
// and length parameters, guess bus width and the controller FSM states.
package candidate_generator_pkg;

  localparam int unsigned MAX_LEN_DEF      = 16;
  localparam logic [7:0]  CHARSET_BASE_DEF = 8'h61;
  localparam int unsigned CHARSET_SIZE_DEF = 26;
  localparam int unsigned GUESS_W          = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_PRESENT,
    ST_STEP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/candidate_odometer.sv
// Combinational single-step increment of the candidate odometer.
// Digit 0 is the first (most significant) character; digit len_i-1 is the
// least significant.  A carry out of digit 0 grows the length by one with
// all digits cleared; at MAX_LEN that carry is reported as overflow.
//   digits_i / len_i   : current odometer
//   digits_o / len_o   : odometer after one step
//   overflow_o         : step ran past the last MAX_LEN-char string
module candidate_odometer
  import candidate_generator_pkg::*;
#(
  parameter int unsigned MAX_LEN      = MAX_LEN_DEF,
  parameter int unsigned CHARSET_SIZE = CHARSET_SIZE_DEF
) (
  input  logic [MAX_LEN-1:0][7:0] digits_i,
  input  logic [7:0]              len_i,
  output logic [MAX_LEN-1:0][7:0] digits_o,
  output logic [7:0]              len_o,
  output logic                    overflow_o
);

  localparam logic [7:0] DIGIT_MAX = 8'(CHARSET_SIZE - 1);

  logic carry;

  always_comb begin
    digits_o   = digits_i;
    len_o      = len_i;
    overflow_o = 1'b0;
    carry      = 1'b1;
    // Walk from the highest digit index down so the least significant
    // active digit (len_i-1) is incremented first; inactive digits are skipped.
    for (int unsigned k = 0; k < MAX_LEN; k++) begin
      if (carry && ((MAX_LEN - 1 - k) < 32'(len_i))) begin
        if (digits_i[MAX_LEN-1-k] == DIGIT_MAX) begin
          digits_o[MAX_LEN-1-k] = '0;
        end else begin
          digits_o[MAX_LEN-1-k] = digits_i[MAX_LEN-1-k] + 8'd1;
          carry                 = 1'b0;
        end
      end
    end
    if (carry) begin
      digits_o = '0;
      if (32'(len_i) >= MAX_LEN) begin
        overflow_o = 1'b1;
      end else begin
        len_o = len_i + 8'd1;
      end
    end
  end

endmodule

// File: rtl/candidate_generator.sv
// Password candidate producer for the MD5 cracking controller.
// Enumerates strings over a contiguous charset in shortlex order, starting at
// start_index and advancing by stride per accepted word.
//   clock        : system clock, rising edge
//   reset        : asynchronous, active-low
//   enable       : run/freeze; low freezes all state and hides guess_valid
//   start_index  : sequence index of the first candidate (0 = first char)
//   stride       : indices advanced per transfer (0 behaves as 1)
//   ready        : consumer accepts the offered word
//   guess        : candidate, bits [0:7] = first char, unused bytes zero
//   guess_len    : candidate length in chars
//   guess_valid  : guess/guess_len offered
//   exhausted    : sequence ran past the last MAX_LEN-char string (sticky)
module candidate_generator
  import candidate_generator_pkg::*;
#(
  parameter int unsigned MAX_LEN      = MAX_LEN_DEF,
  parameter logic [7:0]  CHARSET_BASE = CHARSET_BASE_DEF,
  parameter int unsigned CHARSET_SIZE = CHARSET_SIZE_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [7:0]         start_index,
  input  logic [2:0]         stride,
  input  logic               ready,
  output logic [0:GUESS_W-1] guess,
  output logic [7:0]         guess_len,
  output logic               guess_valid,
  output logic               exhausted
);

  state_e                  state_q, state_d;
  logic [MAX_LEN-1:0][7:0] digits_q, digits_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [0:GUESS_W-1]      guess_q, guess_d;
  logic [7:0]              glen_q, glen_d;
  logic                    valid_q, valid_d;
  logic                    exh_q, exh_d;

  logic [MAX_LEN-1:0][7:0] step_digits;
  logic [7:0]              step_len;
  logic                    step_ovf;

  logic [MAX_LEN-1:0][7:0] pres_digits;
  logic [7:0]              pres_len;

  candidate_odometer #(
    .MAX_LEN      (MAX_LEN),
    .CHARSET_SIZE (CHARSET_SIZE)
  ) u_odometer (
    .digits_i   (digits_q),
    .len_i      (len_q),
    .digits_o   (step_digits),
    .len_o      (step_len),
    .overflow_o (step_ovf)
  );

  function automatic logic [0:GUESS_W-1] pack_guess(
    input logic [MAX_LEN-1:0][7:0] d,
    input logic [7:0]              n
  );
    logic [0:GUESS_W-1] g;
    g = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (i < 32'(n)) g[i*8 +: 8] = CHARSET_BASE + d[i];
    end
    return g;
  endfunction

  // The STEP exit presents the freshly stepped odometer in the same edge it
  // is computed, so the presented value is taken from the odometer output
  // there; SEEK presents the already-settled odometer.
  always_comb begin
    pres_digits = (state_q == ST_STEP) ? step_digits : digits_q;
    pres_len    = (state_q == ST_STEP) ? step_len    : len_q;
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    guess_d  = guess_q;
    glen_d   = glen_q;
    valid_d  = valid_q;
    exh_d    = exh_q;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          digits_d = '0;
          len_d    = 8'd1;
          cnt_d    = start_index;
          state_d  = ST_SEEK;
        end
        ST_SEEK: begin
          if (cnt_q == 8'd0) begin
            guess_d = pack_guess(pres_digits, pres_len);
            glen_d  = pres_len;
            valid_d = 1'b1;
            state_d = ST_PRESENT;
          end else if (step_ovf) begin
            valid_d = 1'b0;
            exh_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            digits_d = step_digits;
            len_d    = step_len;
            cnt_d    = cnt_q - 8'd1;
          end
        end
        ST_PRESENT: begin
          if (ready) begin
            cnt_d   = (stride == 3'd0) ? 8'd1 : {5'd0, stride};
            valid_d = 1'b0;
            state_d = ST_STEP;
          end
        end
        ST_STEP: begin
          if (step_ovf) begin
            valid_d = 1'b0;
            exh_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            digits_d = step_digits;
            len_d    = step_len;
            cnt_d    = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              guess_d = pack_guess(pres_digits, pres_len);
              glen_d  = pres_len;
              valid_d = 1'b1;
              state_d = ST_PRESENT;
            end
          end
        end
        ST_DONE: begin
          valid_d = 1'b0;
          exh_d   = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      digits_q <= '0;
      len_q    <= 8'd1;
      cnt_q    <= '0;
      guess_q  <= '0;
      glen_q   <= '0;
      valid_q  <= 1'b0;
      exh_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      guess_q  <= guess_d;
      glen_q   <= glen_d;
      valid_q  <= valid_d;
      exh_q    <= exh_d;
    end
  end

  assign guess       = guess_q;
  assign guess_len   = glen_q;
  assign guess_valid = valid_q & enable;
  assign exhausted   = exh_q;

endmodule

// File: tb/tb_candidate_generator.sv
module tb_candidate_generator;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [7:0]   start_index = '0;
  logic [2:0]   stride = '0;
  logic         ready = 1'b0;

  logic [0:127] ga, gb;
  logic [7:0]   la, lb;
  logic         va, vb, xa, xb;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [135:0] q_a[$];
  logic [135:0] q_b[$];

  // Behavioural model: sequence position as a plain integer index.
  longint m_pos[2]   = '{0, 0};
  longint m_tgt[2]   = '{0, 0};
  longint m_total[2] = '{0, 0};
  bit     m_started[2] = '{0, 0};
  bit     m_seek[2]    = '{0, 0};
  bit     m_valid[2]   = '{0, 0};
  bit     m_done[2]    = '{0, 0};

  always #5 clock = ~clock;

  candidate_generator dut_a (
    .clock(clock), .reset(reset), .enable(enable), .start_index(start_index),
    .stride(stride), .ready(ready), .guess(ga), .guess_len(la),
    .guess_valid(va), .exhausted(xa)
  );

  candidate_generator #(.MAX_LEN(2)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .start_index(start_index),
    .stride(stride), .ready(ready), .guess(gb), .guess_len(lb),
    .guess_valid(vb), .exhausted(xb)
  );

  function automatic longint total_for(input int maxlen);
    longint p = 1, t = 0;
    for (int k = 1; k <= maxlen; k++) begin
      p = p * 26;
      t = t + p;
      if (t > 64'd1000000000000) return 64'd1000000000000;
    end
    return t;
  endfunction

  // Shortlex index -> left-aligned string bytes and length.
  task automatic cand(input longint idx, output logic [127:0] g, output logic [7:0] len);
    longint n = idx, p = 26;
    int l = 1;
    while (n >= p) begin
      n = n - p;
      p = p * 26;
      l++;
    end
    g = '0;
    for (int i = l - 1; i >= 0; i--) begin
      g[127-8*i -: 8] = 8'h61 + 8'(n % 26);
      n = n / 26;
    end
    len = 8'(l);
  endtask

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_x(input string nm, input int which, input int idx,
                       input logic [7:0] elen, input logic [127:0] eg);
    int sz;
    sz = (which == 0) ? q_a.size() : q_b.size();
    if (idx >= sz) begin
      total_cnt++;
      bad_cnt++;
      $display("FAIL %s: transfer %0d missing, got %0d transfers", nm, idx, sz);
    end else begin
      chk(nm, (which == 0) ? q_a[idx] : q_b[idx], {elen, eg});
    end
  endtask

  task automatic model_edge(input int m);
    if (m_done[m]) return;
    if (!m_started[m]) begin
      m_started[m] = 1;
      m_pos[m]     = 0;
      m_tgt[m]     = longint'(start_index);
      m_seek[m]    = 1;
    end else if (m_valid[m]) begin
      if (ready) begin
        m_valid[m] = 0;
        m_seek[m]  = 0;
        m_tgt[m]   = m_pos[m] + ((stride == 0) ? 1 : longint'(stride));
      end
    end else if (m_pos[m] < m_tgt[m]) begin
      m_pos[m]++;
      if (m_pos[m] >= m_total[m]) m_done[m] = 1;
      else if (m_pos[m] == m_tgt[m] && !m_seek[m]) m_valid[m] = 1;
    end else begin
      m_valid[m] = 1;
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        m_started[m] = 0; m_seek[m] = 0; m_valid[m] = 0; m_done[m] = 0;
        m_pos[m] = 0; m_tgt[m] = 0;
      end
    end else if (enable) begin
      for (int m = 0; m < 2; m++) model_edge(m);
    end
  end

  // Record words that will be transferred at the coming rising edge.
  always @(negedge clock) begin
    if (reset && ready) begin
      if (va) q_a.push_back({la, ga});
      if (vb) q_b.push_back({lb, gb});
    end
  end

  always @(negedge clock) begin
    logic [127:0] eg;
    logic [7:0]   el;
    logic [127:0] g;
    logic [7:0]   l;
    logic         v, x;
    for (int m = 0; m < 2; m++) begin
      g = (m == 0) ? ga : gb;
      l = (m == 0) ? la : lb;
      v = (m == 0) ? va : vb;
      x = (m == 0) ? xa : xb;
      chk($sformatf("valid%0d", m), 136'(v), 136'(m_valid[m] && enable && reset));
      chk($sformatf("exhausted%0d", m), 136'(x), 136'(m_done[m]));
      if (!reset) begin
        chk($sformatf("rst_guess%0d", m), {l, g}, '0);
      end else if (m_valid[m] && enable) begin
        cand(m_pos[m], eg, el);
        chk($sformatf("guess%0d", m), {l, g}, {el, eg});
      end
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset  = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    q_a.delete();
    q_b.delete();
    reset = 1'b1;
  endtask

  task automatic wait_xfers(input int which, input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (((which == 0) ? q_a.size() : q_b.size()) >= n) return;
      @(posedge clock); #1;
    end
    total_cnt++;
    bad_cnt++;
    $display("FAIL wait_xfers: timeout waiting for %0d transfers on dut %0d", n, which);
  endtask

  task automatic wait_valid_a(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (va) return;
      @(posedge clock); #1;
    end
    total_cnt++;
    bad_cnt++;
    $display("FAIL wait_valid: timeout, guess_valid stayed %b", va);
  endtask

  initial begin
    int c;
    m_total[0] = total_for(16);
    m_total[1] = total_for(2);

    // Reset state
    #2;
    chk("reset_a", {xa, va, la, ga}, '0);
    chk("reset_b", {xb, vb, lb, gb}, '0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    // start 0, stride 1, ready high
    start_index = 8'd0; stride = 3'd1; ready = 1'b1; enable = 1'b1;
    wait_xfers(0, 28, 200);
    chk_x("first_a",  0, 0,  8'd1, {8'h61, 120'h0});
    chk_x("z_a",      0, 25, 8'd1, {8'h7a, 120'h0});
    chk_x("aa_a",     0, 26, 8'd2, {16'h6161, 112'h0});
    chk_x("ab_a",     0, 27, 8'd2, {16'h6162, 112'h0});
    chk_x("aa_b",     1, 26, 8'd2, {16'h6161, 112'h0});

    // start 2, stride 3: first valid after 4 enabled edges
    do_reset();
    start_index = 8'd2; stride = 3'd3; ready = 1'b1; enable = 1'b1;
    c = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if (va) begin
        c = i;
        break;
      end
    end
    chk("first_valid_latency", 136'(c), 136'(4));
    wait_xfers(0, 3, 60);
    ready = 1'b0;
    chk_x("c_a", 0, 0, 8'd1, {8'h63, 120'h0});
    chk_x("f_a", 0, 1, 8'd1, {8'h66, 120'h0});
    chk_x("i_a", 0, 2, 8'd1, {8'h69, 120'h0});

    // ready held low: word stays offered
    repeat (13) @(posedge clock);
    #1;
    chk("hold_word", {7'd0, va, la, ga}, {8'd1, 8'd1, 8'h6c, 120'h0});
    chk("hold_count", 136'(q_a.size()), 136'(3));
    ready = 1'b1;
    wait_xfers(0, 4, 10);
    ready = 1'b0;
    chk_x("l_a", 0, 3, 8'd1, {8'h6c, 120'h0});

    // enable falls together with valid&ready: no transfer
    wait_valid_a(20);
    chk("o_offered", {la, ga}, {8'd1, 8'h6f, 120'h0});
    enable = 1'b0;
    ready  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("frozen_count", 136'(q_a.size()), 136'(4));
    enable = 1'b1;
    wait_xfers(0, 6, 30);
    chk_x("o_once", 0, 4, 8'd1, {8'h6f, 120'h0});
    chk_x("r_next", 0, 5, 8'd1, {8'h72, 120'h0});

    // MAX_LEN=2 exhaustion
    do_reset();
    start_index = 8'd0; stride = 3'd0; ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (xb) break;
      @(posedge clock); #1;
    end
    chk("exhausted_b", 136'(xb), 136'(1));
    chk("count_b", 136'(q_b.size()), 136'(702));
    chk_x("zz_b", 1, 701, 8'd2, {16'h7a7a, 112'h0});
    repeat (5) @(posedge clock);
    #1;
    chk("done_sticky_b", {6'd0, xb, vb, 128'h0}, {6'd0, 1'b1, 1'b0, 128'h0});

    // asynchronous reset mid-STEP
    do_reset();
    start_index = 8'd5; stride = 3'd7; ready = 1'b1; enable = 1'b1;
    wait_xfers(0, 1, 30);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_a", {xa, va, la, ga}, '0);
    @(posedge clock); #1;
    q_a.delete();
    q_b.delete();
    reset = 1'b1;
    wait_xfers(0, 1, 30);
    chk_x("restart_a", 0, 0, 8'd1, {8'h66, 120'h0});

    // randomized run, checked every cycle against the model
    for (int i = 0; i < 6000; i++) begin
      @(posedge clock); #1;
      reset  = ($urandom_range(0, 599) != 0);
      enable = ($urandom_range(0, 7) != 0);
      ready  = $urandom_range(0, 1) == 1;
      stride = 3'($urandom_range(0, 7));
      start_index = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 30));
    end
    @(posedge clock); #1;

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
